aes_word_packer: RTL and testbench

// - Input stage ahead of the AES round core. Accepts 32-bit words over a valid/ready bus and packs

---
 rtl/aes_word_packer.sv | 114 +++++++++++
 tb/tb_aes_word_packer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/aes_word_packer.sv
`default_nettype none
// ============================================================================
// aes_word_packer : packs 32-bit words into 128-bit AES state blocks via FIFO
// Revision: 1.0
// ============================================================================

package aes_word_packer_pkg;
  typedef logic [31:0]  ulogic32;
  typedef logic [127:0] ulogic128;
endpackage

module aes_word_packer
  import aes_word_packer_pkg::*;
#(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     in_valid,
  output logic     in_ready,
  input  ulogic32  in_data,
  input  logic     in_last,
  output logic     out_valid,
  input  logic     out_ready,
  output ulogic128 out_data,
  output logic     err_short
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  logic [1:0]    wcnt;
  ulogic32       acc [3];
  ulogic32       blk_word [4];
  ulogic128      new_block;
  ulogic128      mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
  logic [CW-1:0] count, count_next, count_after_pop;
  ulogic128      out_reg;
  logic          err_reg;
  logic          full, closing, fire, push, pop;
  ulogic32       pad_word;

  assign pad_word = {4{PAD_BYTE}};
  assign full     = (count == C_FULL);
  assign closing  = (wcnt == 2'd3) || in_last;
  // Hold off only a word that would close a block while there is no slot for it.
  assign in_ready = !(full && closing);
  assign fire     = in_valid && in_ready;
  assign push     = fire && closing;
  assign pop      = out_valid && out_ready;

  for (genvar k = 0; k < 3; k++) begin : g_word
    assign blk_word[k] = (wcnt > 2'(k))  ? acc[k]  :
                         (wcnt == 2'(k)) ? in_data : pad_word;
  end
  assign blk_word[3] = (wcnt == 2'd3) ? in_data : pad_word;
  assign new_block   = {blk_word[0], blk_word[1], blk_word[2], blk_word[3]};

  assign count_after_pop = count - CW'(pop);
  assign count_next      = count_after_pop + CW'(push);
  assign rd_ptr_next     = !pop ? rd_ptr :
                           (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt    <= '0;
      acc[0]  <= '0;
      acc[1]  <= '0;
      acc[2]  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      out_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      err_reg <= push && in_last && (wcnt != 2'd3);
      if (fire) begin
        if (closing) begin
          wcnt <= '0;
        end else begin
          acc[wcnt] <= in_data;
          wcnt      <= wcnt + 2'd1;
        end
      end
      if (push) begin
        wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      // Registered head: the new block bypasses memory when it becomes head.
      if (count_next != '0) begin
        out_reg <= (count_after_pop == '0) ? new_block : mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= new_block;
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = out_reg;
  assign err_short = err_reg;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) push |-> (!full || pop));

endmodule

`default_nettype wire

// File: tb/tb_aes_word_packer.sv
`default_nettype none
// Bench for aes_word_packer: directed literal checks plus a queue-based block model.
module tb_aes_word_packer;
  localparam int DEPTH = 2;

  logic         clk = 0;
  logic         reset = 1;
  logic         in_valid = 0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 0;
  logic         out_valid;
  logic         out_ready = 0;
  logic [127:0] out_data;
  logic         err_short;

  int total = 0;
  int bad = 0;

  aes_word_packer #(.FIFO_DEPTH(DEPTH), .PAD_BYTE(8'h00)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .err_short(err_short)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: list of words in the open block, queue of finished blocks.
  logic [31:0]  cur[$];
  logic [127:0] q[$];
  logic [127:0] last_out = '0;
  logic         exp_err = 0;

  function automatic logic [127:0] make_block(input logic [31:0] w[$]);
    logic [127:0] b;
    for (int k = 0; k < 4; k++)
      b[127-32*k -: 32] = (k < w.size()) ? w[k] : 32'h0000_0000;
    return b;
  endfunction

  always @(negedge clk) begin
    logic exp_ir, do_pop, do_fire, new_err;
    if (reset) begin
      cur.delete(); q.delete(); last_out = '0; exp_err = 0;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_data", out_data, 128'(0));
      chk("rst_err_short", 128'(err_short), 128'(0));
    end else begin
      exp_ir = !((q.size() == DEPTH) && (cur.size() == 3 || in_last));
      chk("in_ready", 128'(in_ready), 128'(exp_ir));
      chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
      chk("out_data", out_data, last_out);
      chk("err_short", 128'(err_short), 128'(exp_err));
      do_pop  = (q.size() > 0) && out_ready;
      do_fire = in_valid && exp_ir;
      new_err = 0;
      if (do_pop) begin
        last_out = q[0];
        void'(q.pop_front());
      end
      if (do_fire) begin
        cur.push_back(in_data);
        if (cur.size() == 4 || in_last) begin
          new_err = in_last && (cur.size() < 4);
          q.push_back(make_block(cur));
          cur.delete();
        end
      end
      if (q.size() > 0) last_out = q[0];
      exp_err = new_err;
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    logic ok;
    in_valid = 1; in_data = d; in_last = l;
    forever begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      if (ok) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 128'(0), 128'(1));
        break;
      end
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1;
    while (out_valid && n < 100) begin idle(1); n++; end
    chk("drain_timeout", 128'(out_valid), 128'(0));
    idle(1);
  endtask

  initial begin
    int len;
    logic lst;
    idle(2);
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    reset = 0;
    idle(1);

    // 1: basic block, visible one cycle after the 4th word
    out_ready = 1;
    send(32'h00112233, 0); send(32'h44556677, 0); send(32'h8899aabb, 0); send(32'hccddeeff, 0);
    chk("t1_valid", 128'(out_valid), 128'(1));
    chk("t1_data", out_data, 128'h00112233_44556677_8899aabb_ccddeeff);
    drain();

    // 2: back-pressure with FIFO full
    out_ready = 0;
    for (int i = 1; i <= 11; i++) send(32'h1000_0000 + 32'(i), 0);
    in_valid = 1; in_data = 32'h1000_000c; in_last = 0;
    @(negedge clk);
    chk("t2_in_ready_drop", 128'(in_ready), 128'(0));
    idle(3);
    chk("t2_head_stable", out_data, 128'h10000001_10000002_10000003_10000004);
    out_ready = 1;
    send(32'h1000_000c, 0);
    drain();

    // 3: short block with padding and err_short pulse
    send(32'hAAAAAAAA, 0); send(32'hBBBBBBBB, 1);
    chk("t3_err_pulse", 128'(err_short), 128'(1));
    chk("t3_data", out_data, 128'hAAAAAAAA_BBBBBBBB_00000000_00000000);
    idle(1);
    chk("t3_err_clear", 128'(err_short), 128'(0));
    drain();

    // 4: in_last on 4th word is a normal close
    send(32'h1, 0); send(32'h2, 0); send(32'h3, 0); send(32'h4, 1);
    chk("t4_no_err", 128'(err_short), 128'(0));
    chk("t4_data", out_data, 128'h00000001_00000002_00000003_00000004);
    send(32'h5, 0); send(32'h6, 0); send(32'h7, 0); send(32'h8, 0);
    chk("t4_next", out_data, 128'h00000005_00000006_00000007_00000008);
    drain();

    // 5: random traffic against the model
    fork
      begin
        for (int b = 0; b < 1000; b++) begin
          len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 4;
          for (int j = 0; j < len; j++) begin
            lst = (j == len - 1) && ((len < 4) || ($urandom_range(0, 3) == 0));
            send($urandom, lst);
            if ($urandom_range(0, 5) == 0) idle(1);
          end
        end
      end
      begin
        repeat (9000) begin
          out_ready = ($urandom_range(0, 9) < 7);
          @(posedge clk); #1;
        end
      end
    join_any
    disable fork;
    drain();

    // 6: reset mid-block with one block queued
    out_ready = 0;
    send(32'h11111111, 0); send(32'h22222222, 0); send(32'h33333333, 0); send(32'h44444444, 0);
    send(32'h55555555, 0); send(32'h66666666, 0);
    reset = 1;
    #1;
    chk("t6_valid_rst", 128'(out_valid), 128'(0));
    chk("t6_data_rst", out_data, 128'(0));
    idle(2);
    reset = 0;
    out_ready = 1;
    send(32'h77777777, 0); send(32'h88888888, 0); send(32'h99999999, 0); send(32'haaaaaaaa, 0);
    chk("t6_clean", out_data, 128'h77777777_88888888_99999999_aaaaaaaa);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
